// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, data-RAM handshake, branch resolve.
// Optional MEM_MISALIGN_CHK_EN flags misaligned accesses instead of issuing them.
module mem_stage #(
    parameter int unsigned MAX_WAIT   = 15,
    parameter logic [31:0] RST_PC_TGT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        es_valid,
    output logic        ms_allowin,
    input  logic [5:0]  es_ctrl,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] wr_data,
    input  logic [4:0]  es_rd,
    input  logic [31:0] nx_pc,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [4:0]  ms_rd,
    output logic        ms_reg_write,
    output logic [31:0] ms_result,
    output logic        ms_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic        branch_q, branch_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem2reg_q, mem2reg_d;
    logic        reg_write_q, reg_write_d;
    logic        zero_q, zero_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] br_target_q, br_target_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        br_fired_q, br_fired_d;
    logic [7:0]  wd_cnt_q, wd_cnt_d;

    logic        is_mem;
    logic        es_mem;
    logic        ready_go;
    logic        load_fire;
    logic        wd_hit;
    logic        unused_alu_src_op;

    assign unused_alu_src_op = es_ctrl[1];

    assign is_mem    = mem_read_q | mem_write_q;
    assign es_mem    = es_ctrl[4] | es_ctrl[3];
    assign ready_go  = !is_mem || (state_q == DONE);
    assign wd_hit    = (wd_cnt_q == WD_LAST);

    assign ms_allowin     = !valid_q || (ready_go && ws_allowin);
    assign load_fire      = es_valid && ms_allowin;
    assign ms_to_ws_valid = valid_q && ready_go;

    assign br_taken  = valid_q && branch_q && zero_q && !br_fired_q;
    assign br_target = br_target_q;

    assign dm_req   = valid_q && (state_q == REQ);
    assign dm_we    = dm_req && mem_write_q;
    assign dm_addr  = {alu_res_q[31:2], 2'b00};
    assign dm_wdata = wr_data_q;

    // A combined read+write op behaves as a store, so only a pure load returns RAM data.
    assign ms_rd        = rd_q;
    assign ms_reg_write = reg_write_q;
    assign ms_result    = (mem2reg_q && mem_read_q && !mem_write_q) ? rdata_q : alu_res_q;
    assign ms_err       = valid_q && err_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        branch_d    = branch_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem2reg_d   = mem2reg_q;
        reg_write_d = reg_write_q;
        zero_d      = zero_q;
        alu_res_d   = alu_res_q;
        wr_data_d   = wr_data_q;
        rd_d        = rd_q;
        br_target_d = br_target_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        br_fired_d  = br_fired_q;
        wd_cnt_d    = wd_cnt_q;

        if (br_taken) begin
            br_fired_d = 1'b1;
        end

        unique case (state_q)
            IDLE: ;
            REQ: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (dm_gnt) begin
                    if (mem_write_q) begin
                        state_d = DONE;
                    end else if (dm_rvalid) begin
                        state_d = DONE;
                        rdata_d = dm_rdata;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (wd_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            WAIT: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (dm_rvalid) begin
                    state_d = DONE;
                    rdata_d = dm_rdata;
                end else if (wd_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            DONE: begin
                if (ws_allowin) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_fire) begin
            valid_d     = 1'b1;
            branch_d    = es_ctrl[5];
            mem_read_d  = es_ctrl[4];
            mem_write_d = es_ctrl[3];
            mem2reg_d   = es_ctrl[2];
            reg_write_d = es_ctrl[0];
            zero_d      = zero;
            alu_res_d   = alu_result;
            wr_data_d   = wr_data;
            rd_d        = es_rd;
            br_target_d = nx_pc;
            rdata_d     = 32'd0;
            err_d       = 1'b0;
            br_fired_d  = 1'b0;
            wd_cnt_d    = 8'd0;
            state_d     = es_mem ? REQ : IDLE;
`ifdef MEM_MISALIGN_CHK_EN
            if (es_mem && (alu_result[1:0] != 2'b00)) begin
                state_d     = DONE;
                err_d       = 1'b1;
                reg_write_d = 1'b0;
            end
`endif
        end else if (ms_to_ws_valid && ws_allowin) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            branch_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem2reg_q   <= 1'b0;
            reg_write_q <= 1'b0;
            zero_q      <= 1'b0;
            alu_res_q   <= 32'd0;
            wr_data_q   <= 32'd0;
            rd_q        <= 5'd0;
            br_target_q <= RST_PC_TGT;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            br_fired_q  <= 1'b0;
            wd_cnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            branch_q    <= branch_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem2reg_q   <= mem2reg_d;
            reg_write_q <= reg_write_d;
            zero_q      <= zero_d;
            alu_res_q   <= alu_res_d;
            wr_data_q   <= wr_data_d;
            rd_q        <= rd_d;
            br_target_q <= br_target_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            br_fired_q  <= br_fired_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        es_valid;
    logic        ms_allowin;
    logic [5:0]  es_ctrl;
    logic        zero;
    logic [31:0] alu_result;
    logic [31:0] wr_data;
    logic [4:0]  es_rd;
    logic [31:0] nx_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [4:0]  ms_rd;
    logic        ms_reg_write;
    logic [31:0] ms_result;
    logic        ms_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(15), .RST_PC_TGT(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .es_valid(es_valid), .ms_allowin(ms_allowin),
        .es_ctrl(es_ctrl), .zero(zero), .alu_result(alu_result), .wr_data(wr_data),
        .es_rd(es_rd), .nx_pc(nx_pc), .br_taken(br_taken), .br_target(br_target),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_rd(ms_rd),
        .ms_reg_write(ms_reg_write), .ms_result(ms_result), .ms_err(ms_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] w, input logic [4:0] rd,
                         input logic z, input logic [31:0] pc);
        es_valid = 1'b1; es_ctrl = c; alu_result = a;
        wr_data = w; es_rd = rd; zero = z; nx_pc = pc;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({dm_req, dm_we, ms_to_ws_valid, br_taken, ms_err, ms_reg_write} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b required 000000",
                {dm_req, dm_we, ms_to_ws_valid, br_taken, ms_err, ms_reg_write});
        end
        n_chk++;
        if (br_target !== 32'h0 || ms_result !== 32'h0 || dm_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: tgt %h res %h addr %h required 0",
                br_target, ms_result, dm_addr);
        end
        rst_n = 1'b0;
        tick();
        n_chk++;
        if (ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL reset_allowin: got %b required 1", ms_allowin);
        end
    endtask

    task automatic test_alu();
        issue(6'b000001, 32'h1234, 32'h0, 5'd5, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        #1;
        n_chk++;
        if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'h1234 || ms_rd !== 5'd5
            || ms_reg_write !== 1'b1 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL alu_out: v %b res %h rd %0d rw %b req %b required 1 1234 5 1 0",
                ms_to_ws_valid, ms_result, ms_rd, ms_reg_write, dm_req);
        end
        tick();
        n_chk++;
        if (ms_to_ws_valid !== 1'b0 || dm_req !== 1'b0) begin
            n_fail++; $display("FAIL alu_drain: v %b req %b required 0 0", ms_to_ws_valid, dm_req);
        end
    endtask

    task automatic test_load();
        int bad;
        issue(6'b010101, 32'h100, 32'h0, 5'd7, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h100
                || ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) bad++;
            tick();
        end
        dm_gnt = 1'b1;
        #1;
        if (dm_req !== 1'b1 || ms_allowin !== 1'b0) bad++;
        tick();
        dm_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF;
            end
            #1;
            if (dm_req !== 1'b0 || ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b0) bad++;
            tick();
        end
        dm_rvalid = 1'b0; dm_rdata = 32'h0;
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL load_wait: %0d bad cycles required 0", bad);
        end
        n_chk++;
        if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'hDEADBEEF || ms_rd !== 5'd7) begin
            n_fail++; $display("FAIL load_done: v %b res %h rd %0d required 1 deadbeef 7",
                ms_to_ws_valid, ms_result, ms_rd);
        end
        tick();
        n_chk++;
        if (ms_to_ws_valid !== 1'b0) begin
            n_fail++; $display("FAIL load_drain: v %b required 0", ms_to_ws_valid);
        end
    endtask

    task automatic test_store();
        issue(6'b001000, 32'h104, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        dm_gnt = 1'b1;
        #1;
        n_chk++;
        if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 32'hA5A5A5A5
            || dm_addr !== 32'h104 || ms_to_ws_valid !== 1'b0) begin
            n_fail++; $display("FAIL store_req: req %b we %b wd %h addr %h v %b",
                dm_req, dm_we, dm_wdata, dm_addr, ms_to_ws_valid);
        end
        tick();
        dm_gnt = 1'b0;
        #1;
        n_chk++;
        if (dm_req !== 1'b0 || dm_we !== 1'b0 || ms_to_ws_valid !== 1'b1) begin
            n_fail++; $display("FAIL store_done: req %b we %b v %b required 0 0 1",
                dm_req, dm_we, ms_to_ws_valid);
        end
        // read+write together acts as a store; address low bits dropped
        issue(6'b011101, 32'h10B, 32'h11, 5'd3, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
        #1;
        n_chk++;
        if (dm_we !== 1'b1 || dm_addr !== 32'h108) begin
            n_fail++; $display("FAIL rw_req: we %b addr %h required 1 00000108", dm_we, dm_addr);
        end
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        n_chk++;
        if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'h10B) begin
            n_fail++; $display("FAIL rw_result: v %b res %h required 1 0000010b",
                ms_to_ws_valid, ms_result);
        end
        tick();
    endtask

    task automatic test_branch();
        issue(6'b100000, 32'h0, 32'h0, 5'd0, 1'b1, 32'h40);
        tick();
        es_valid = 1'b0;
        #1;
        n_chk++;
        if (br_taken !== 1'b1 || br_target !== 32'h40) begin
            n_fail++; $display("FAIL br_taken: tk %b tgt %h required 1 00000040", br_taken, br_target);
        end
        tick();
        n_chk++;
        if (br_taken !== 1'b0) begin
            n_fail++; $display("FAIL br_pulse: tk %b required 0", br_taken);
        end
        issue(6'b100000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h80);
        tick();
        es_valid = 1'b0;
        #1;
        n_chk++;
        if (br_taken !== 1'b0 || br_target !== 32'h80) begin
            n_fail++; $display("FAIL br_not: tk %b tgt %h required 0 00000080", br_taken, br_target);
        end
        tick();
        // stalled taken branch still pulses once
        ws_allowin = 1'b0;
        issue(6'b100000, 32'h0, 32'h0, 5'd0, 1'b1, 32'hC0);
        tick();
        es_valid = 1'b0;
        #1;
        n_chk++;
        if (br_taken !== 1'b1) begin
            n_fail++; $display("FAIL br_stall_first: tk %b required 1", br_taken);
        end
        tick();
        n_chk++;
        if (br_taken !== 1'b0 || ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin
            n_fail++; $display("FAIL br_stall_hold: tk %b v %b ai %b required 0 1 0",
                br_taken, ms_to_ws_valid, ms_allowin);
        end
        ws_allowin = 1'b1;
        tick();
    endtask

    task automatic test_watchdog();
        int bad;
        issue(6'b010101, 32'h200, 32'h0, 5'd9, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (dm_req !== 1'b1 || ms_to_ws_valid !== 1'b0 || ms_err !== 1'b0) bad++;
            tick();
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL wd_wait: %0d bad cycles required 0", bad);
        end
        n_chk++;
        if (dm_req !== 1'b0 || ms_to_ws_valid !== 1'b1 || ms_err !== 1'b1
            || ms_result !== 32'h0) begin
            n_fail++; $display("FAIL wd_expire: req %b v %b err %b res %h required 0 1 1 0",
                dm_req, ms_to_ws_valid, ms_err, ms_result);
        end
        issue(6'b000001, 32'h55, 32'h0, 5'd1, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        #1;
        n_chk++;
        if (ms_err !== 1'b0 || ms_result !== 32'h55) begin
            n_fail++; $display("FAIL wd_clear: err %b res %h required 0 00000055", ms_err, ms_result);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(6'b000001, 32'hA1, 32'h0, 5'd1, 1'b0, 32'h0);
        tick();
        issue(6'b001000, 32'h300, 32'h77, 5'd0, 1'b0, 32'h0);
        #1;
        n_chk++;
        if (ms_allowin !== 1'b1 || ms_result !== 32'hA1 || ms_to_ws_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_alu: ai %b res %h v %b required 1 000000a1 1",
                ms_allowin, ms_result, ms_to_ws_valid);
        end
        tick();
        es_valid = 1'b0;
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        issue(6'b010101, 32'h304, 32'h0, 5'd4, 1'b0, 32'h0);
        #1;
        n_chk++;
        if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1) begin
            n_fail++; $display("FAIL b2b_store_done: v %b ai %b required 1 1", ms_to_ws_valid, ms_allowin);
        end
        tick();
        es_valid = 1'b0;
        #1;
        n_chk++;
        if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'h304) begin
            n_fail++; $display("FAIL b2b_load_req: req %b we %b addr %h required 1 0 00000304",
                dm_req, dm_we, dm_addr);
        end
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hCAFE0001;
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        n_chk++;
        if (ms_to_ws_valid !== 1'b1 || ms_result !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL b2b_gnt_rvalid: v %b res %h required 1 cafe0001",
                ms_to_ws_valid, ms_result);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(6'b010101, 32'h400, 32'h0, 5'd2, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (dm_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_req: req %b required 0", dm_req);
        end
        tick();
        rst_n = 1'b0;
        tick();
        issue(6'b010101, 32'h404, 32'h0, 5'd2, 1'b0, 32'h0);
        tick();
        es_valid = 1'b0;
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (dm_req !== 1'b0 || ms_to_ws_valid !== 1'b0 || br_target !== 32'h0) begin
            n_fail++; $display("FAIL rst_wait: req %b v %b tgt %h required 0 0 0",
                dm_req, ms_to_ws_valid, br_target);
        end
        tick();
        rst_n = 1'b0;
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h12345678;
        tick();
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        n_chk++;
        if (dm_req !== 1'b0 || ms_to_ws_valid !== 1'b0 || ms_result !== 32'h0) begin
            n_fail++; $display("FAIL rst_late: req %b v %b res %h required 0 0 0",
                dm_req, ms_to_ws_valid, ms_result);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        es_valid = 1'b0; es_ctrl = 6'b0; zero = 1'b0;
        alu_result = 32'h0; wr_data = 32'h0; es_rd = 5'd0; nx_pc = 32'h0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        ws_allowin = 1'b1;
        tick();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_watchdog();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage; upstream of write-back.
- Holds the EX/MEM pipeline register and runs a request/grant/response handshake to data RAM for loads and stores.
- Resolves taken branches (branch & zero) toward fetch.
- Presents the write-back value (load data or ALU result) with a valid/allow-in handshake.

Parameters:
- MAX_WAIT, 15: watchdog limit, in cycles, spent in REQ+WAIT before the access is forced complete with an error; range 1..255.
- RST_PC_TGT, 32'h0000_0000: reset value of br_target.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-high (rst_n = 1 asserts reset)
- es_valid  in  1  execute stage presents an instruction
- ms_allowin  out  1  mem stage can accept an instruction this cycle
- es_ctrl  in  6  {branch, mem_read, mem_write, mem2reg, alu_src_op, reg_write}
- zero  in  1  ALU zero flag
- alu_result  in  32  ALU result / memory address
- wr_data  in  32  store data
- es_rd  in  5  destination register
- nx_pc  in  32  branch target
- br_taken  out  1  taken branch in this stage
- br_target  out  32  registered nx_pc
- dm_req  out  1  data RAM request
- dm_we  out  1  1 = store
- dm_addr  out  32  {alu_result[31:2], 2'b00}
- dm_wdata  out  32  store data
- dm_gnt  in  1  request accepted
- dm_rvalid  in  1  load data valid
- dm_rdata  in  32  load data
- ws_allowin  in  1  write-back can accept
- ms_to_ws_valid  out  1  result valid to write-back
- ms_rd  out  5  destination register
- ms_reg_write  out  1  reg_write control bit
- ms_result  out  32  mem2reg ? load data : ALU result
- ms_err  out  1  watchdog expiry on current instruction

Behaviour:
- Reset (async, rst_n = 1): internal valid = 0; FSM = IDLE; all outputs 0 except br_target = RST_PC_TGT; dm_req drops in the same cycle. Reset mid-access abandons the transaction; a late dm_gnt/dm_rvalid after reset is ignored.
- Load: pipeline register captures all es_* inputs when es_valid && ms_allowin; valid <= 1. Otherwise valid <= 0 once the result has been taken (ms_to_ws_valid && ws_allowin).
- ready_go = 1 for non-memory instructions, and = 1 when the FSM is in DONE.
- ms_allowin = !valid || (ready_go && ws_allowin).
- ms_to_ws_valid = valid && ready_go.
- br_taken = valid && branch && zero (combinational from the register). It is a 1-cycle pulse per instruction. Upstream owns the flush.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE -> REQ when an instruction with mem_read|mem_write is captured.
  - REQ: dm_req = 1. On dm_gnt: store -> DONE; load -> WAIT.
  - WAIT: dm_req = 0. On dm_rvalid, capture dm_rdata -> DONE.
  - DONE: on ws_allowin -> REQ if a new memory op is captured the same cycle, else IDLE.
- Both mem_read and mem_write set: handled as a store; ms_result = alu_result.
- dm_gnt and dm_rvalid in the same REQ cycle for a load: go straight to DONE with the data captured.
- Watchdog: 8-bit counter cleared on entering REQ, incremented each REQ/WAIT cycle. When it reaches MAX_WAIT: move to DONE, ms_err = 1, load data = 0, dm_req deasserted. ms_err clears when the next instruction is captured.
- Non-memory instruction: zero-bubble pass-through, 1-cycle latency.
- Memory instruction: latency = grant wait + response wait + 1.
- Back-to-back instructions are supported without a bubble when ws_allowin = 1.

Optional Feature:
- MEM_MISALIGN_CHK_EN defined: a memory op with alu_result[1:0] != 0 issues no dm_req. It goes IDLE -> DONE with ms_err = 1 and ms_reg_write forced to 0.
- Undefined: the low address bits are silently ignored (dm_addr is word-aligned), and access proceeds normally.

Test Plan:
1. ALU op, ctrl=6'b000001, alu_result=32'h1234, rd=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, ms_result=32'h1234, ms_rd=5, dm_req never 1.
2. Load addr 32'h100, gnt after 2 cycles, rvalid with 32'hDEADBEEF 3 cycles later -> ms_allowin=0 throughout, ms_result=32'hDEADBEEF, ms_to_ws_valid high exactly when DONE.
3. Store addr 32'h104, wr_data 32'hA5A5A5A5, gnt immediate -> dm_we=1, dm_wdata=32'hA5A5A5A5 for 1 cycle, DONE next cycle.
4. Branch ctrl=6'b100000, zero=1, nx_pc=32'h40 -> br_taken 1 cycle, br_target=32'h40; with zero=0 -> br_taken stays 0.
5. Load with no gnt, MAX_WAIT=15 -> DONE after 15 cycles, ms_err=1, ms_result=0.
6. Assert rst_n during WAIT -> dm_req=0 and ms_to_ws_valid=0 immediately; a late dm_rvalid causes no output.
